// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, the operand bundle carried from operand fetch to execute,
// and the source-operand select helper.
package operand_fetch_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [XLEN-1:0]      op1;
        logic [XLEN-1:0]      op2;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_we;
    } operand_bundle_t;

    // x0 reads as zero; a same-cycle writeback overrides the stale bank value
    function automatic logic [XLEN-1:0] select_operand(
        input logic [REG_IDX_W-1:0] idx,
        input logic                 fwd,
        input logic [XLEN-1:0]      wb_data,
        input logic [XLEN-1:0]      bank_data
    );
        if (idx == '0) return '0;
        if (fwd)       return wb_data;
        return bank_data;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode, register-bank, writeback and execute signals of the operand fetch stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface operand_fetch_stage_if #(
    parameter int BANK_WIDTH     = operand_fetch_stage_pkg::REG_IDX_W,
    parameter int REGISTER_WIDTH = operand_fetch_stage_pkg::XLEN,
    parameter int PC_WIDTH       = operand_fetch_stage_pkg::PC_W
);
    logic                      flush;
    logic                      id_valid;
    logic                      id_ready;
    logic [PC_WIDTH-1:0]       id_pc;
    logic [BANK_WIDTH-1:0]     id_rs1;
    logic [BANK_WIDTH-1:0]     id_rs2;
    logic [BANK_WIDTH-1:0]     id_rd;
    logic                      id_rd_we;
    logic [REGISTER_WIDTH-1:0] id_imm;
    logic [BANK_WIDTH-1:0]     rs1_sel;
    logic [BANK_WIDTH-1:0]     rs2_sel;
    logic [REGISTER_WIDTH-1:0] rs1_data;
    logic [REGISTER_WIDTH-1:0] rs2_data;
    logic                      wb_valid;
    logic [BANK_WIDTH-1:0]     wb_rd;
    logic [REGISTER_WIDTH-1:0] wb_data;
    logic                      ex_valid;
    logic                      ex_ready;
    logic [PC_WIDTH-1:0]       ex_pc;
    logic [REGISTER_WIDTH-1:0] ex_op1;
    logic [REGISTER_WIDTH-1:0] ex_op2;
    logic [REGISTER_WIDTH-1:0] ex_imm;
    logic [BANK_WIDTH-1:0]     ex_rd;
    logic                      ex_rd_we;

    modport slave (
        input  flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd_we, id_imm,
        input  rs1_data, rs2_data, wb_valid, wb_rd, wb_data, ex_ready,
        output id_ready, rs1_sel, rs2_sel,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rd_we
    );

    modport master (
        output flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd_we, id_imm,
        output rs1_data, rs2_data, wb_valid, wb_rd, wb_data, ex_ready,
        input  id_ready, rs1_sel, rs2_sel,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rd_we
    );

endinterface

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module operand_fetch_stage_reg_scoreboard #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             rel_en,
    input  logic [IDX_W-1:0] rel_idx,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy
);
    localparam int NREG = 1 << IDX_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A new writer claiming r in the same cycle r retires keeps r busy
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (rel_en) busy_d[rel_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];
    assign rd_busy  = busy_q[rd_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: bank read, scoreboard hazard stall, registered handoff to execute.
// Optional OPERAND_FORWARDING_EN bypasses same-cycle writeback data into the operands.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int BANK_WIDTH     = REG_IDX_W,
    parameter int REGISTER_WIDTH = XLEN,
    parameter int PC_WIDTH       = PC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_fetch_stage_if.slave  bus
);
    logic                      fwd1, fwd2;
    logic                      rs1_busy, rs2_busy, rd_busy;
    logic                      hazard, id_ready, accept;
    logic                      set_en, rel_en;
    logic [REGISTER_WIDTH-1:0] op1, op2;
    logic [PC_WIDTH-1:0]       pc;
    operand_bundle_t           ex_q, ex_d;
    logic                      ex_valid_q, ex_valid_d;

`ifdef OPERAND_FORWARDING_EN
    assign fwd1 = bus.wb_valid && (bus.wb_rd == bus.id_rs1) && (bus.id_rs1 != '0);
    assign fwd2 = bus.wb_valid && (bus.wb_rd == bus.id_rs2) && (bus.id_rs2 != '0);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign bus.rs1_sel = bus.id_rs1;
    assign bus.rs2_sel = bus.id_rs2;

    assign hazard   = (rs1_busy && !fwd1) || (rs2_busy && !fwd2) || (bus.id_rd_we && rd_busy);
    assign id_ready = rst && (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign accept   = bus.id_valid && id_ready;
    assign set_en   = accept && bus.id_rd_we && (bus.id_rd != '0);
    // A squashed writer will never reach writeback, so its claim is dropped here
    assign rel_en   = bus.flush && ex_valid_q && ex_q.rd_we;

    assign op1 = select_operand(bus.id_rs1, fwd1, bus.wb_data, bus.rs1_data);
    assign op2 = select_operand(bus.id_rs2, fwd2, bus.wb_data, bus.rs2_data);
    assign pc  = bus.id_pc;

    operand_fetch_stage_reg_scoreboard #(
        .IDX_W (BANK_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_idx  (bus.id_rd),
        .clr_en   (bus.wb_valid),
        .clr_idx  (bus.wb_rd),
        .rel_en   (rel_en),
        .rel_idx  (ex_q.rd),
        .rs1_idx  (bus.id_rs1),
        .rs2_idx  (bus.id_rs2),
        .rd_idx   (bus.id_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_d.pc    = pc;
            ex_d.op1   = op1;
            ex_d.op2   = op2;
            ex_d.imm   = bus.id_imm;
            ex_d.rd    = bus.id_rd;
            ex_d.rd_we = bus.id_rd_we && (bus.id_rd != '0);
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign bus.id_ready = id_ready;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_q.pc;
    assign bus.ex_op1   = ex_q.op1;
    assign bus.ex_op2   = ex_q.op2;
    assign bus.ex_imm   = ex_q.imm;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.ex_rd_we = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register bank.
// Expectations follow OPERAND_FORWARDING_EN when it is defined for the build.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic [31:0] bank [32];

    always #5 clk = ~clk;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Bank writes land at the writeback edge, reads are combinational
    always @(posedge clk) begin
        if (bus.wb_valid && bus.wb_rd != 5'd0) bank[bus.wb_rd] <= bus.wb_data;
    end
    assign bus.rs1_data = bank[bus.rs1_sel];
    assign bus.rs2_data = bank[bus.rs2_sel];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic we,
                                 input logic [31:0] pc, input logic [31:0] imm);
        bus.id_valid = v;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
        bus.id_rd_we = we;
        bus.id_pc    = pc;
        bus.id_imm   = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        bank[1] = 32'h5;
        bank[2] = 32'h7;
        bank[3] = 32'h33;
        bank[4] = 32'h44;
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h0;
        bus.ex_ready = 1'b1;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'hAA, 32'h1);

        // Reset with decode offering a writer
        tick();
        checkOutput("rst_id_ready_c1", {63'd0, bus.id_ready}, 64'd0);
        checkOutput("rst_ex_valid_c1", {63'd0, bus.ex_valid}, 64'd0);
        tick();
        checkOutput("rst_id_ready_c2", {63'd0, bus.id_ready}, 64'd0);
        checkOutput("rst_ex_valid_c2", {63'd0, bus.ex_valid}, 64'd0);
        checkOutput("rst_busy", {32'd0, dut.u_scoreboard.busy_q}, 64'd0);
        checkOutput("rst_ex_pc", {32'd0, bus.ex_pc}, 64'd0);
        checkOutput("rst_ex_op1", {32'd0, bus.ex_op1}, 64'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();

        // Back-to-back independent instructions
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h100, 32'h11);
        #1;
        checkOutput("b2b_ready0", {63'd0, bus.id_ready}, 64'd1);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h104, 32'h22);
        #1;
        checkOutput("b2b_valid0", {63'd0, bus.ex_valid}, 64'd1);
        checkOutput("b2b_op1", {32'd0, bus.ex_op1}, 64'h5);
        checkOutput("b2b_op2", {32'd0, bus.ex_op2}, 64'h7);
        checkOutput("b2b_pc0", {32'd0, bus.ex_pc}, 64'h100);
        checkOutput("b2b_imm0", {32'd0, bus.ex_imm}, 64'h11);
        checkOutput("b2b_ready1", {63'd0, bus.id_ready}, 64'd1);
        tick();
        checkOutput("b2b_pc1", {32'd0, bus.ex_pc}, 64'h104);
        checkOutput("b2b_valid1", {63'd0, bus.ex_valid}, 64'd1);
        checkOutput("b2b_imm1", {32'd0, bus.ex_imm}, 64'h22);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("b2b_drain", {63'd0, bus.ex_valid}, 64'd0);

        // RAW on x3
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h200, 32'h0);
        tick();
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'h204, 32'h0);
        #1;
        checkOutput("raw_writer_rd", {59'd0, bus.ex_rd}, 64'd3);
        checkOutput("raw_writer_we", {63'd0, bus.ex_rd_we}, 64'd1);
        checkOutput("raw_stall0", {63'd0, bus.id_ready}, 64'd0);
        tick();
        checkOutput("raw_stall1", {63'd0, bus.id_ready}, 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_data  = 32'h55;
        #1;
`ifdef OPERAND_FORWARDING_EN
        checkOutput("raw_fwd_ready", {63'd0, bus.id_ready}, 64'd1);
        tick();
        bus.wb_valid = 1'b0;
`else
        checkOutput("raw_wb_stall", {63'd0, bus.id_ready}, 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        checkOutput("raw_after_wb_ready", {63'd0, bus.id_ready}, 64'd1);
        tick();
`endif
        checkOutput("raw_op1", {32'd0, bus.ex_op1}, 64'h55);
        checkOutput("raw_pc", {32'd0, bus.ex_pc}, 64'h204);
        checkOutput("raw_valid", {63'd0, bus.ex_valid}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();

        // Backpressure holds the registered operands
        bus.ex_ready = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h300, 32'h33);
        tick();
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 32'h304, 32'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_ready", {63'd0, bus.id_ready}, 64'd0);
            checkOutput("bp_pc", {32'd0, bus.ex_pc}, 64'h300);
            checkOutput("bp_op1", {32'd0, bus.ex_op1}, 64'h5);
            checkOutput("bp_valid", {63'd0, bus.ex_valid}, 64'd1);
            tick();
        end
        bus.ex_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {63'd0, bus.id_ready}, 64'd1);
        tick();
        checkOutput("bp_next_pc", {32'd0, bus.ex_pc}, 64'h304);
        checkOutput("bp_next_op1", {32'd0, bus.ex_op1}, 64'h7);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();

        // Flush of a held writer of x4
        bus.ex_ready = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'h400, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("fl_held_valid", {63'd0, bus.ex_valid}, 64'd1);
        checkOutput("fl_held_rd", {59'd0, bus.ex_rd}, 64'd4);
        bus.flush = 1'b1;
        #1;
        checkOutput("fl_ready", {63'd0, bus.id_ready}, 64'd0);
        tick();
        bus.flush = 1'b0;
        checkOutput("fl_valid", {63'd0, bus.ex_valid}, 64'd0);
        checkOutput("fl_busy4", {63'd0, dut.u_scoreboard.busy_q[4]}, 64'd0);
        bus.ex_ready = 1'b1;
        applyStimulus(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 32'h404, 32'h0);
        #1;
        checkOutput("fl_reader_ready", {63'd0, bus.id_ready}, 64'd1);
        tick();
        checkOutput("fl_reader_op1", {32'd0, bus.ex_op1}, 64'h44);
        checkOutput("fl_reader_pc", {32'd0, bus.ex_pc}, 64'h404);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();

        // x0 as destination and source
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 32'h500, 32'h0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'hDEAD;
        #1;
        checkOutput("x0_ready0", {63'd0, bus.id_ready}, 64'd1);
        tick();
        bus.wb_valid = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h504, 32'h0);
        #1;
        checkOutput("x0_rd_we", {63'd0, bus.ex_rd_we}, 64'd0);
        checkOutput("x0_op1", {32'd0, bus.ex_op1}, 64'h0);
        checkOutput("x0_op2", {32'd0, bus.ex_op2}, 64'h5);
        checkOutput("x0_ready1", {63'd0, bus.id_ready}, 64'd1);
        tick();
        checkOutput("x0_pc1", {32'd0, bus.ex_pc}, 64'h504);
        checkOutput("x0_busy", {32'd0, dut.u_scoreboard.busy_q}, 64'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
